// File: rtl/soc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_arbiter
// Brief    : Two-master round-robin arbiter for the data memory slave port,
//            one outstanding transaction, with a slave-hang timeout.
// Revision : 1.0 - initial release
// ============================================================================
module soc_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic            s_gnt,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  state_t          r_state, w_state_nxt;
  logic            r_prio, w_prio_nxt;
  logic            r_owner, w_owner_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_win, w_expire, w_done, w_done_err;
  logic            w_s_req_nxt, w_s_we_nxt;
  logic [AW-1:0]   w_s_addr_nxt;
  logic [DW-1:0]   w_s_wdata_nxt;
  logic [DW/8-1:0] w_s_wstrb_nxt;
  logic            w_m0_gnt_nxt, w_m0_rvalid_nxt, w_m0_err_nxt;
  logic            w_m1_gnt_nxt, w_m1_rvalid_nxt, w_m1_err_nxt;
  logic [DW-1:0]   w_m0_rdata_nxt, w_m1_rdata_nxt;

  // 0 selects m0; prio only breaks ties when both masters request
  assign w_win    = (m0_req && m1_req) ? r_prio : m1_req;
  // Counter value that will become TIMEOUT at this edge
  assign w_expire = (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_prio_nxt      = r_prio;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_s_req_nxt     = s_req;
    w_s_we_nxt      = s_we;
    w_s_addr_nxt    = s_addr;
    w_s_wdata_nxt   = s_wdata;
    w_s_wstrb_nxt   = s_wstrb;
    w_m0_gnt_nxt    = 1'b0;
    w_m1_gnt_nxt    = 1'b0;
    w_m0_rvalid_nxt = 1'b0;
    w_m1_rvalid_nxt = 1'b0;
    w_m0_err_nxt    = 1'b0;
    w_m1_err_nxt    = 1'b0;
    w_m0_rdata_nxt  = m0_rdata;
    w_m1_rdata_nxt  = m1_rdata;
    w_done          = 1'b0;
    w_done_err      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          w_owner_nxt   = w_win;
          w_prio_nxt    = ~w_win;
          w_cnt_nxt     = '0;
          w_s_req_nxt   = 1'b1;
          w_s_we_nxt    = w_win ? m1_we    : m0_we;
          w_s_addr_nxt  = w_win ? m1_addr  : m0_addr;
          w_s_wdata_nxt = w_win ? m1_wdata : m0_wdata;
          w_s_wstrb_nxt = w_win ? m1_wstrb : m0_wstrb;
          w_m0_gnt_nxt  = ~w_win;
          w_m1_gnt_nxt  = w_win;
          w_state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
        if (w_expire) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end else if (s_gnt) begin
          w_s_req_nxt = 1'b0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
        // A real completion beats a coincident expiry
        if (s_rvalid) begin
          w_done = 1'b1;
        end else if (w_expire) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_done) begin
      w_s_req_nxt = 1'b0;
      w_state_nxt = ST_RESP;
      if (r_owner) begin
        w_m1_rvalid_nxt = 1'b1;
        w_m1_err_nxt    = w_done_err;
        w_m1_rdata_nxt  = w_done_err ? '0 : s_rdata;
      end else begin
        w_m0_rvalid_nxt = 1'b1;
        w_m0_err_nxt    = w_done_err;
        w_m0_rdata_nxt  = w_done_err ? '0 : s_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      s_req     <= 1'b0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      m0_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_gnt    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prio    <= w_prio_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      s_req     <= w_s_req_nxt;
      s_we      <= w_s_we_nxt;
      s_addr    <= w_s_addr_nxt;
      s_wdata   <= w_s_wdata_nxt;
      s_wstrb   <= w_s_wstrb_nxt;
      m0_gnt    <= w_m0_gnt_nxt;
      m0_rvalid <= w_m0_rvalid_nxt;
      m0_rdata  <= w_m0_rdata_nxt;
      m0_err    <= w_m0_err_nxt;
      m1_gnt    <= w_m1_gnt_nxt;
      m1_rvalid <= w_m1_rvalid_nxt;
      m1_rdata  <= w_m1_rdata_nxt;
      m1_err    <= w_m1_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the riscv_soc data memory port.
- m0 is the CPU load/store port; m1 is the debug/program-loader port used by benches to preload and inspect memory.
- Round-robin fairness, one outstanding transaction, registered slave request, and a timeout that returns an error when the slave hangs.

Parameters:
- AW, 32, address width
- DW, 32, data width; multiple of 8
- TIMEOUT, 16, maximum cycles spent in ISSUE+WAIT before an error completion; must be ≥2
- CW, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  request; held until m0_gnt
- m0_we  in  1  1=write 0=read
- m0_addr  in  AW  address
- m0_wdata  in  DW  write data
- m0_wstrb  in  DW/8  byte enables
- m0_gnt  out  1  one-cycle accept pulse
- m0_rvalid  out  1  one-cycle completion pulse
- m0_rdata  out  DW  read data, valid with m0_rvalid
- m0_err  out  1  timeout error, valid with m0_rvalid
- m1_*  same set and meaning as m0_*
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_wstrb  out  DW/8  slave byte enables
- s_gnt  in  1  slave accepts while s_req=1
- s_rvalid  in  1  slave completion (read data or write ack)
- s_rdata  in  DW  slave read data

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- On reset: state=IDLE, prio=0 (m0 favoured), timeout counter=0.
- rst asserted in any state forces the reset condition at that edge.
  - Any in-flight transaction is abandoned: no rvalid is issued and s_req drops the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Request requirement: at least one of m0_req/m1_req high at the edge.
  - Winner when only one requests: that master.
  - Winner when both request: the master selected by prio.
  - At that edge the winner's we/addr/wdata/wstrb are latched into the s_* registers.
  - s_req<=1 and winner gnt<=1 (pulse in the following cycle).
  - Next state is ISSUE; prio<=~winner.
  - No request: stay in IDLE.
- ISSUE:
  - s_req held at 1 with stable fields until s_gnt=1.
  - On s_gnt: s_req<=0, next state is WAIT.
  - m*_req ignored in ISSUE, WAIT and RESP.
- WAIT:
  - On s_rvalid: latch s_rdata into the owner's rdata, owner rvalid<=1, err<=0, next state is RESP.
  - s_rvalid in the same cycle as s_gnt is ignored; the earliest valid completion is the cycle after s_gnt.
  - Writes also complete on s_rvalid; rdata is returned as whatever s_rdata holds.
- RESP: rvalid/err clear, next state is IDLE. Back-to-back transactions therefore have a 1-cycle idle gap.
- Timeout:
  - The counter clears on the IDLE->ISSUE transition and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT without completion, all of the following happen at that edge: owner rvalid<=1, err<=1, rdata<=0, s_req<=0, next state is RESP.
  - s_rvalid arriving in the same cycle as expiry wins: normal completion, err=0.
- s_rvalid or s_gnt seen outside WAIT/ISSUE is ignored.
- Minimum latency, req sampled at edge k:
  - gnt high in cycle k+1.
  - s_req high in cycle k+1.
  - With s_gnt in k+1 and s_rvalid in k+2: rvalid high in cycle k+3.
- Both masters requesting continuously are served alternately: m0, m1, m0, ...

Test Plan:
- Single read: m0 reads addr 0x100, slave grants at once and returns 0xDEADBEEF one cycle later -> m0_gnt in cycle 1, s_addr=0x100, s_we=0, m0_rvalid in cycle 3 with m0_rdata=0xDEADBEEF, m0_err=0; m1 outputs stay 0.
- Contention: m0 and m1 both request from reset with prio=0 -> m0 served first, then m1; with both held continuously the grant order is m0, m1, m0, m1.
- Write with slave stall: m1 writes 0x12345678, wstrb=4'b0011, addr 0x40; s_gnt delayed 3 cycles -> s_* fields stable while s_req=1; completion on s_rvalid with m1_err=0.
- Timeout: TIMEOUT=16, slave grants but never sends s_rvalid -> m0_rvalid=1, m0_err=1, m0_rdata=0 exactly 16 cycles after the ISSUE entry; FSM returns to IDLE and the next m1 request is served normally.
- Boundary: s_rvalid arrives in the same cycle the counter hits TIMEOUT -> err=0 and rdata equals s_rdata. A spurious s_rvalid while in IDLE -> no rvalid pulse.
- Reset mid-operation: rst asserted while in WAIT -> all outputs 0 next cycle, no m*_rvalid, prio=0. A late s_rvalid after reset is ignored.
